// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution-stage hazard controller: operand select codes,
// shadow pipeline entry layout and stage indices.
package exec_ctrl_pkg;

    localparam int ADDR_BITS  = 5;
    localparam int SEL_BITS   = 3;
    localparam int NUM_STAGES = 5;

    localparam int STG_EX  = 0;
    localparam int STG_DM1 = 1;
    localparam int STG_DM2 = 2;
    localparam int STG_DM3 = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [SEL_BITS-1:0] {
        SEL_RS     = 3'd0,
        SEL_PC_IMM = 3'd1,
        SEL_DM1    = 3'd2,
        SEL_DM2    = 3'd3,
        SEL_DM3    = 3'd4,
        SEL_WB     = 3'd5
    } sel_e;

    typedef struct packed {
        logic                 we;
        logic                 load;
        logic [ADDR_BITS-1:0] rd;
    } shadow_entry_t;

    // x0 is hard-wired zero, so it never matches an in-flight writer.
    function automatic logic writes_reg(input shadow_entry_t e, input logic [ADDR_BITS-1:0] rs);
        return e.we && (rs != '0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Compares one decode source register against the in-flight shadow entries and
// returns the forwarding select, a load-use flag and a raw any-writer flag.
module hazard_compare
    import exec_ctrl_pkg::*;
(
    input  logic [ADDR_BITS-1:0] rs_i,
    input  logic                 use_alt_i,
    input  shadow_entry_t        ex_i,
    input  shadow_entry_t        dm1_i,
    input  shadow_entry_t        dm2_i,
    input  shadow_entry_t        dm3_i,
    output sel_e                 sel_o,
    output logic                 load_use_o,
    output logic                 any_match_o
);

    logic matchEx, matchDm1, matchDm2, matchDm3;

    assign matchEx  = writes_reg(ex_i,  rs_i);
    assign matchDm1 = writes_reg(dm1_i, rs_i);
    assign matchDm2 = writes_reg(dm2_i, rs_i);
    assign matchDm3 = writes_reg(dm3_i, rs_i);

    assign any_match_o = matchEx | matchDm1 | matchDm2 | matchDm3;

    // Codes name where the producer will sit when the consumer reaches EX,
    // one stage further on; the youngest producer wins.
    always_comb begin
        sel_o      = SEL_RS;
        load_use_o = 1'b0;
        if (use_alt_i) begin
            sel_o = SEL_PC_IMM;
        end else if (matchEx) begin
            sel_o      = SEL_DM1;
            load_use_o = ex_i.load;
        end else if (matchDm1) begin
            sel_o      = SEL_DM2;
            load_use_o = dm1_i.load;
        end else if (matchDm2) begin
            sel_o      = SEL_DM3;
            load_use_o = dm2_i.load;
        end else if (matchDm3) begin
            sel_o      = SEL_WB;
        end
    end

endmodule

// File: rtl/execution_hazard_controller.sv
// Execution-stage sequencer: shadow pipeline of in-flight writers, registered ALU
// operand forwarding selects, and stall/clear generation for hazards and branches.
module execution_hazard_controller
    import exec_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = ADDR_BITS,
    parameter int SEL_W      = SEL_BITS,
    parameter int PERF_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MEM_STALL,
    input  logic                  BRANCH_TAKEN,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS1_ADDRESS,
    input  logic [REG_ADDR_W-1:0] ID_RS2_ADDRESS,
    input  logic [REG_ADDR_W-1:0] ID_RD_ADDRESS,
    input  logic                  ID_RD_WRITE_ENABLE,
    input  logic                  ID_IS_LOAD,
    input  logic                  ID_IS_STORE,
    input  logic                  ID_IN1_USES_PC,
    input  logic                  ID_IN2_USES_IMM,
    output logic [SEL_W-1:0]      ALU_IN1_MUX_SELECT,
    output logic [SEL_W-1:0]      ALU_IN2_MUX_SELECT,
    output logic                  STALL_FETCH,
    output logic                  STALL_DECODE,
    output logic                  STALL_EXECUTION_STAGE,
    output logic                  CLEAR_FETCH,
    output logic                  CLEAR_DECODE,
    output logic [PERF_W-1:0]     STALL_COUNT,
    output logic [PERF_W-1:0]     FLUSH_COUNT
);

    shadow_entry_t [NUM_STAGES-1:0] shadow_q, shadow_d;
    logic [SEL_W-1:0]  sel1_q, sel1_d, sel2_q, sel2_d;
    logic [PERF_W-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

    sel_e sel1, sel2;
    logic loadUse1, loadUse2, anyMatch1, anyMatch2;
    logic hazard;
    shadow_entry_t issueEntry;

    hazard_compare u_cmp1 (
        .rs_i        (ID_RS1_ADDRESS),
        .use_alt_i   (ID_IN1_USES_PC),
        .ex_i        (shadow_q[STG_EX]),
        .dm1_i       (shadow_q[STG_DM1]),
        .dm2_i       (shadow_q[STG_DM2]),
        .dm3_i       (shadow_q[STG_DM3]),
        .sel_o       (sel1),
        .load_use_o  (loadUse1),
        .any_match_o (anyMatch1)
    );

    hazard_compare u_cmp2 (
        .rs_i        (ID_RS2_ADDRESS),
        .use_alt_i   (ID_IN2_USES_IMM),
        .ex_i        (shadow_q[STG_EX]),
        .dm1_i       (shadow_q[STG_DM1]),
        .dm2_i       (shadow_q[STG_DM2]),
        .dm3_i       (shadow_q[STG_DM3]),
        .sel_o       (sel2),
        .load_use_o  (loadUse2),
        .any_match_o (anyMatch2)
    );

    // Store data is read from the regfile rather than forwarded, so any older writer blocks it.
    assign hazard = ID_VALID & (loadUse1 | loadUse2 | (ID_IS_STORE & anyMatch2));

    always_comb begin
        issueEntry      = '0;
        issueEntry.we   = ID_VALID & ID_RD_WRITE_ENABLE & (ID_RD_ADDRESS != '0);
        issueEntry.load = issueEntry.we & ID_IS_LOAD;
        issueEntry.rd   = ID_RD_ADDRESS;
    end

    always_comb begin
        STALL_FETCH           = 1'b0;
        STALL_DECODE          = 1'b0;
        STALL_EXECUTION_STAGE = MEM_STALL;
        CLEAR_FETCH           = 1'b0;
        CLEAR_DECODE          = 1'b0;
        if (MEM_STALL) begin
            STALL_FETCH  = 1'b1;
            STALL_DECODE = 1'b1;
        end else if (BRANCH_TAKEN) begin
            CLEAR_FETCH  = 1'b1;
            CLEAR_DECODE = 1'b1;
        end else if (hazard) begin
            STALL_FETCH  = 1'b1;
            STALL_DECODE = 1'b1;
            CLEAR_DECODE = 1'b1;
        end
    end

    // Branch and hazard both inject a bubble into EX; only a clean issue loads real selects.
    always_comb begin
        shadow_d   = shadow_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (!MEM_STALL) begin
            shadow_d[STG_WB]  = shadow_q[STG_DM3];
            shadow_d[STG_DM3] = shadow_q[STG_DM2];
            shadow_d[STG_DM2] = shadow_q[STG_DM1];
            shadow_d[STG_DM1] = shadow_q[STG_EX];
            shadow_d[STG_EX]  = '0;
            sel1_d            = SEL_RS;
            sel2_d            = SEL_RS;
            if (BRANCH_TAKEN) begin
                if (flushCnt_q != '1) flushCnt_d = flushCnt_q + 1'b1;
            end else if (hazard) begin
                if (stallCnt_q != '1) stallCnt_d = stallCnt_q + 1'b1;
            end else if (ID_VALID) begin
                shadow_d[STG_EX] = issueEntry;
                sel1_d           = sel1;
                sel2_d           = sel2;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_q   <= '0;
            sel1_q     <= '0;
            sel2_q     <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign ALU_IN1_MUX_SELECT = sel1_q;
    assign ALU_IN2_MUX_SELECT = sel2_q;
    assign STALL_COUNT        = stallCnt_q;
    assign FLUSH_COUNT        = flushCnt_q;

endmodule

// File: tb/tb_execution_hazard_controller.sv
// Directed bench for execution_hazard_controller: a vector table for forwarding
// and load-use, plus hand sequences for branch, memory stall, store and reset.
module tb_execution_hazard_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_STALL, BRANCH_TAKEN, ID_VALID;
    logic [4:0]  ID_RS1_ADDRESS, ID_RS2_ADDRESS, ID_RD_ADDRESS;
    logic        ID_RD_WRITE_ENABLE, ID_IS_LOAD, ID_IS_STORE, ID_IN1_USES_PC, ID_IN2_USES_IMM;
    logic [2:0]  ALU_IN1_MUX_SELECT, ALU_IN2_MUX_SELECT;
    logic        STALL_FETCH, STALL_DECODE, STALL_EXECUTION_STAGE, CLEAR_FETCH, CLEAR_DECODE;
    logic [31:0] STALL_COUNT, FLUSH_COUNT;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs1, rs2, rd;
        logic       we, ld, st, pc, imm, br, ms;
        logic       sf, sd, se, cf, cd;
        logic [2:0] s1, s2;
    } vec_t;

    vec_t table_q[$];

    always #5 CLK = ~CLK;

    execution_hazard_controller dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .MEM_STALL             (MEM_STALL),
        .BRANCH_TAKEN          (BRANCH_TAKEN),
        .ID_VALID              (ID_VALID),
        .ID_RS1_ADDRESS        (ID_RS1_ADDRESS),
        .ID_RS2_ADDRESS        (ID_RS2_ADDRESS),
        .ID_RD_ADDRESS         (ID_RD_ADDRESS),
        .ID_RD_WRITE_ENABLE    (ID_RD_WRITE_ENABLE),
        .ID_IS_LOAD            (ID_IS_LOAD),
        .ID_IS_STORE           (ID_IS_STORE),
        .ID_IN1_USES_PC        (ID_IN1_USES_PC),
        .ID_IN2_USES_IMM       (ID_IN2_USES_IMM),
        .ALU_IN1_MUX_SELECT    (ALU_IN1_MUX_SELECT),
        .ALU_IN2_MUX_SELECT    (ALU_IN2_MUX_SELECT),
        .STALL_FETCH           (STALL_FETCH),
        .STALL_DECODE          (STALL_DECODE),
        .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE),
        .CLEAR_FETCH           (CLEAR_FETCH),
        .CLEAR_DECODE          (CLEAR_DECODE),
        .STALL_COUNT           (STALL_COUNT),
        .FLUSH_COUNT           (FLUSH_COUNT)
    );

    // Expected stall/clear flags: sf sd cf cd; the execution-stage stall always follows ms.
    function automatic vec_t mk(input int valid, input int rs1, input int rs2, input int rd,
                                input int we, input int ld, input int st, input int pc, input int imm,
                                input int br, input int ms, input int sf, input int sd, input int cf,
                                input int cd, input int s1, input int s2);
        vec_t v;
        v.valid = 1'(valid); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.we = 1'(we); v.ld = 1'(ld); v.st = 1'(st); v.pc = 1'(pc); v.imm = 1'(imm);
        v.br = 1'(br); v.ms = 1'(ms);
        v.sf = 1'(sf); v.sd = 1'(sd); v.se = 1'(ms); v.cf = 1'(cf); v.cd = 1'(cd);
        v.s1 = 3'(s1); v.s2 = 3'(s2);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        ID_VALID           = v.valid;
        ID_RS1_ADDRESS     = v.rs1;
        ID_RS2_ADDRESS     = v.rs2;
        ID_RD_ADDRESS      = v.rd;
        ID_RD_WRITE_ENABLE = v.we;
        ID_IS_LOAD         = v.ld;
        ID_IS_STORE        = v.st;
        ID_IN1_USES_PC     = v.pc;
        ID_IN2_USES_IMM    = v.imm;
        BRANCH_TAKEN       = v.br;
        MEM_STALL          = v.ms;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge CLK);
        driveInputs(v);
        #1;
        checkOutput({tag, ".stallFetch"},  32'(STALL_FETCH),           32'(v.sf));
        checkOutput({tag, ".stallDecode"}, 32'(STALL_DECODE),          32'(v.sd));
        checkOutput({tag, ".stallExec"},   32'(STALL_EXECUTION_STAGE), 32'(v.se));
        checkOutput({tag, ".clearFetch"},  32'(CLEAR_FETCH),           32'(v.cf));
        checkOutput({tag, ".clearDecode"}, 32'(CLEAR_DECODE),          32'(v.cd));
        @(posedge CLK);
        #1;
        checkOutput({tag, ".sel1"}, 32'(ALU_IN1_MUX_SELECT), 32'(v.s1));
        checkOutput({tag, ".sel2"}, 32'(ALU_IN2_MUX_SELECT), 32'(v.s2));
    endtask

    function automatic vec_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        vec_t v;
        driveInputs(nop());
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst.sel1",   32'(ALU_IN1_MUX_SELECT), 0);
        checkOutput("rst.sel2",   32'(ALU_IN2_MUX_SELECT), 0);
        checkOutput("rst.stallCnt", STALL_COUNT, 0);
        checkOutput("rst.flushCnt", FLUSH_COUNT, 0);
        checkOutput("rst.stallDecode", 32'(STALL_DECODE), 0);
        checkOutput("rst.clearFetch",  32'(CLEAR_FETCH), 0);
        RST = 1'b0;

        // Forwarding distance: back-to-back, gap of three, gap of four; PC/IMM overrides.
        //              v rs1 rs2 rd we ld st pc im br ms  sf sd cf cd  s1 s2
        table_q.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        table_q.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 5, 3, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        table_q.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 10, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        table_q.push_back(mk(1, 3, 4, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 3, 4, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mk(1, 5, 4, 15, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        // lw x7 then add x8,x7,x7: three hazard cycles, then both operands from WB.
        table_q.push_back(mk(1, 1, 0, 7, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        table_q.push_back(mk(1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        table_q.push_back(mk(1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        table_q.push_back(mk(1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        table_q.push_back(mk(1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5));

        foreach (table_q[i]) applyStimulus(table_q[i], $sformatf("vec%0d", i));
        checkOutput("loadUse.stallCnt", STALL_COUNT, 3);
        checkOutput("loadUse.flushCnt", FLUSH_COUNT, 0);

        // Two writers of x5 (EX and DM2): youngest wins; x0 never forwards.
        applyStimulus(mk(1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "young.a");
        applyStimulus(mk(1, 3, 4, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "young.b");
        applyStimulus(mk(1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "young.c");
        applyStimulus(mk(1, 3, 5, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "young.use");
        applyStimulus(mk(1, 3, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "x0.write");
        applyStimulus(mk(1, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "x0.use");

        // Branch overrides a concurrent load-use.
        applyStimulus(mk(1, 3, 0, 7, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "br.load");
        applyStimulus(mk(1, 7, 7, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0), "br.flush");
        for (int i = 0; i < 3; i++) applyStimulus(nop(), $sformatf("br.drain%0d", i));
        checkOutput("br.flushCnt", FLUSH_COUNT, 1);
        checkOutput("br.stallCnt", STALL_COUNT, 3);

        // Memory stall in the middle of a load-use: everything freezes, then resumes.
        applyStimulus(mk(1, 1, 0, 20, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "ms.load");
        applyStimulus(mk(1, 20, 3, 22, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "ms.haz0");
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(1, 20, 3, 22, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), $sformatf("ms.frz%0d", i));
        checkOutput("ms.stallCntFrozen", STALL_COUNT, 4);
        applyStimulus(mk(1, 20, 3, 22, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "ms.haz1");
        applyStimulus(mk(1, 20, 3, 22, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "ms.haz2");
        applyStimulus(mk(1, 20, 3, 22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0), "ms.issue");
        checkOutput("ms.stallCnt", STALL_COUNT, 6);

        // sw x9 with x9 in DM3: exactly one stall cycle.
        applyStimulus(mk(1, 1, 2, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st.wr");
        applyStimulus(mk(1, 3, 4, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st.f0");
        applyStimulus(mk(1, 3, 4, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st.f1");
        applyStimulus(mk(1, 3, 4, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st.f2");
        applyStimulus(mk(1, 1, 9, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0), "st.haz");
        applyStimulus(mk(1, 1, 9, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "st.issue");
        checkOutput("st.stallCnt", STALL_COUNT, 7);

        // Reset pulse during a load-use stall.
        applyStimulus(mk(1, 1, 0, 21, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "rst.load");
        @(negedge CLK);
        v = mk(1, 21, 3, 23, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        driveInputs(v);
        #1;
        checkOutput("rst.preStall", 32'(STALL_DECODE), 1);
        RST = 1'b1;
        #1;
        checkOutput("rst.mid.sel1",        32'(ALU_IN1_MUX_SELECT), 0);
        checkOutput("rst.mid.sel2",        32'(ALU_IN2_MUX_SELECT), 0);
        checkOutput("rst.mid.stallCnt",    STALL_COUNT, 0);
        checkOutput("rst.mid.flushCnt",    FLUSH_COUNT, 0);
        checkOutput("rst.mid.stallFetch",  32'(STALL_FETCH), 0);
        checkOutput("rst.mid.stallDecode", 32'(STALL_DECODE), 0);
        checkOutput("rst.mid.clearDecode", 32'(CLEAR_DECODE), 0);
        #1;
        RST = 1'b0;
        applyStimulus(mk(1, 21, 3, 23, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.after");
        checkOutput("rst.after.stallCnt", STALL_COUNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
